// File: rtl/nn_axil_pkg.sv
// Shared definitions for the zyNet AXI4-Lite command master: opcodes, register map,
// response codes and sequencer states.
package nn_axil_pkg;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_READ      = 2'd1,
    OP_READ_CMP  = 2'd2,
    OP_WAIT_INTR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_B,
    ST_RD_A,
    ST_RD_R,
    ST_WAIT_I,
    ST_RSP
  } mst_state_e;

  localparam logic [31:0] REG_WEIGHT     = 32'd0;
  localparam logic [31:0] REG_BIAS       = 32'd4;
  localparam logic [31:0] REG_RESULT     = 32'd8;
  localparam logic [31:0] REG_LAYER      = 32'd12;
  localparam logic [31:0] REG_NEURON     = 32'd16;
  localparam logic [31:0] REG_NEURON_OUT = 32'd20;
  localparam logic [31:0] REG_STATUS     = 32'd24;
  localparam logic [31:0] REG_SOFT_RESET = 32'd28;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Any response other than OKAY is reported as an error, EXOKAY included.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on rdata while !empty.
module nn_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nn_axil_cmd_master.sv
// AXI4-Lite master sequencer for the zyNet control slave: executes queued write, read,
// compare-read and wait-for-interrupt commands and keeps match/mismatch counters.
module nn_axil_cmd_master
  import nn_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    intr_in,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    match_count,
  output logic [CNT_WIDTH-1:0]    mismatch_count,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int unsigned    FW      = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam bit             WD_EN   = TIMEOUT_CYCLES != 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  mst_state_e              state_q, state_d;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]           fifo_wdata, fifo_rdata;
  cmd_op_e                 head_op;
  cmd_op_e                 op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    aw_pend_q, w_pend_q;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [WD_W-1:0]         wd_cnt_q;
  logic                    wd_to_q, wd_active, wd_hit;
  logic                    intr_d_q, intr_seen_q, intr_rise, intr_consume;
  logic                    cmp_evt;
  logic [CNT_WIDTH-1:0]    match_q, mismatch_q;
  logic                    timeout_q;

  assign fifo_wdata = {cmd_op, cmd_addr, cmd_data};
  assign cmd_ready  = ~fifo_full;
  assign fifo_push  = cmd_valid & ~fifo_full;
  assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;
  assign head_op    = cmd_op_e'(fifo_rdata[FW-1 -: 2]);

  nn_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

  assign wd_active = (state_q == ST_WR) || (state_q == ST_WR_B) || (state_q == ST_RD_A) ||
                     (state_q == ST_RD_R) || (state_q == ST_WAIT_I);
  assign wd_hit    = WD_EN && wd_active && !wd_to_q && (wd_cnt_q == WD_LAST);

  assign intr_rise    = intr_in & ~intr_d_q;
  assign intr_consume = (state_q == ST_WAIT_I) & intr_seen_q;
  assign cmp_evt      = (state_q == ST_RD_R) & r_hs & (op_q == OP_READ_CMP);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_WRITE:              state_d = ST_WR;
            OP_READ, OP_READ_CMP:  state_d = ST_RD_A;
            default:               state_d = ST_WAIT_I;
          endcase
        end
      end
      ST_WR: begin
        // Each channel finishes on its own handshake; leave once neither is outstanding.
        if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) state_d = ST_WR_B;
      end
      ST_WR_B:   if (b_hs) state_d = ST_RSP;
      ST_RD_A:   if (ar_hs) state_d = ST_RD_R;
      ST_RD_R:   if (r_hs) state_d = ST_RSP;
      ST_WAIT_I: if (intr_seen_q || wd_hit) state_d = ST_RSP;
      ST_RSP:    if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state_q == ST_WR) & aw_pend_q;
    m_axi_wvalid  = (state_q == ST_WR) & w_pend_q;
    m_axi_bready  = state_q == ST_WR_B;
    m_axi_arvalid = state_q == ST_RD_A;
    m_axi_rready  = state_q == ST_RD_R;
    rsp_valid     = state_q == ST_RSP;
    busy          = ~fifo_empty | (state_q != ST_IDLE);
  end

  assign m_axi_awaddr   = addr_q;
  assign m_axi_awprot   = '0;
  assign m_axi_wdata    = data_q;
  assign m_axi_wstrb    = '1;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arprot   = '0;
  assign rsp_data       = rdata_q;
  assign rsp_err        = err_q;
  assign match_count    = match_q;
  assign mismatch_count = mismatch_q;
  assign timeout_err    = timeout_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        op_q      <= head_op;
        addr_q    <= fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
        data_q    <= fifo_rdata[DATA_WIDTH-1:0];
        rdata_q   <= '0;
        err_q     <= 1'b0;
        aw_pend_q <= 1'b1;
        w_pend_q  <= 1'b1;
      end
      if (state_q == ST_WR) begin
        if (aw_hs) aw_pend_q <= 1'b0;
        if (w_hs)  w_pend_q  <= 1'b0;
      end
      if ((state_q == ST_WR_B) && b_hs) err_q <= resp_is_err(m_axi_bresp) | wd_to_q | wd_hit;
      if ((state_q == ST_RD_R) && r_hs) begin
        rdata_q <= m_axi_rdata;
        err_q   <= resp_is_err(m_axi_rresp) | wd_to_q | wd_hit;
      end
      if ((state_q == ST_WAIT_I) && !intr_seen_q && wd_hit) err_q <= 1'b1;
    end
  end

  // Watchdog restarts per command and freezes once it fires so the error stays attached.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else if (!wd_active) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else if (wd_hit) begin
      wd_to_q  <= 1'b1;
    end else if (!wd_to_q) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      intr_d_q    <= 1'b0;
      intr_seen_q <= 1'b0;
    end else begin
      intr_d_q <= intr_in;
      if (intr_rise)         intr_seen_q <= 1'b1;
      else if (intr_consume) intr_seen_q <= 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      match_q    <= '0;
      mismatch_q <= '0;
      timeout_q  <= 1'b0;
    end else if (cnt_clr) begin
      match_q    <= '0;
      mismatch_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (wd_hit) timeout_q <= 1'b1;
      if (cmp_evt) begin
        if (m_axi_rdata == data_q) begin
          if (match_q != '1) match_q <= match_q + CNT_WIDTH'(1);
        end else begin
          if (mismatch_q != '1) mismatch_q <= mismatch_q + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_axil_cmd_master.sv
// Directed plus randomized bench for nn_axil_cmd_master with a scripted AXI-Lite slave
// and a transaction-level expectation model.
module tb_nn_axil_cmd_master;
  import nn_axil_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 64;
  localparam int unsigned FD = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic          intr_in, cnt_clr, timeout_err, busy;
  logic [CW-1:0] match_count, mismatch_count;

  always #5 clk = ~clk;

  nn_axil_cmd_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (FD),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .s_axi_aclk     (clk),           .s_axi_aresetn  (rst_n),
    .cmd_valid      (cmd_valid),     .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),        .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),      .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),     .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),       .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awprot   (m_axi_awprot),  .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready), .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),   .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),  .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),  .m_axi_bready   (m_axi_bready),
    .m_axi_araddr   (m_axi_araddr),  .m_axi_arprot   (m_axi_arprot),
    .m_axi_arvalid  (m_axi_arvalid), .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),   .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),  .m_axi_rready   (m_axi_rready),
    .intr_in        (intr_in),       .cnt_clr        (cnt_clr),
    .match_count    (match_count),   .mismatch_count (mismatch_count),
    .timeout_err    (timeout_err),   .busy           (busy)
  );

  int checks = 0;
  int failures = 0;

  // Slave script: per-command responses and channel delays.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit stall = 1'b0, stall_r = 1'b0;
  logic [1:0]  bresp_q[$];
  logic [1:0]  rresp_q[$];
  logic [31:0] rdata_q[$];
  logic [31:0] awaddr_log[$], wdata_log[$], araddr_log[$];
  logic [3:0]  wstrb_log[$];
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic aw_hs_wvalid, w_hs_awvalid;

  // Expectation model.
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  logic [31:0] exp_aw_q[$], exp_wd_q[$], exp_ar_q[$];
  int m_match = 0, m_mis = 0;

  logic [31:0] offs [8];

  initial begin
    m_axi_awready = 1'b0;
    forever begin
      @(negedge clk);
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !stall) begin
        repeat (aw_dly) @(negedge clk);
        if (m_axi_awvalid && !stall) begin
          m_axi_awready = 1'b1;
          awaddr_log.push_back(m_axi_awaddr);
          aw_hs_wvalid = m_axi_wvalid;
          aw_cnt++;
        end
      end
    end
  end

  initial begin
    m_axi_wready = 1'b0;
    forever begin
      @(negedge clk);
      m_axi_wready = 1'b0;
      if (m_axi_wvalid && !stall) begin
        repeat (w_dly) @(negedge clk);
        if (m_axi_wvalid && !stall) begin
          m_axi_wready = 1'b1;
          wdata_log.push_back(m_axi_wdata);
          wstrb_log.push_back(m_axi_wstrb);
          w_hs_awvalid = m_axi_awvalid;
          w_cnt++;
        end
      end
    end
  end

  initial begin
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      m_axi_bvalid = 1'b0;
      if (b_cnt < aw_cnt && b_cnt < w_cnt && m_axi_bready) begin
        repeat (b_dly) @(negedge clk);
        if (bresp_q.size() != 0) m_axi_bresp = bresp_q.pop_front();
        else                     m_axi_bresp = 2'b00;
        m_axi_bvalid = 1'b1;
        b_cnt++;
      end
    end
  end

  initial begin
    m_axi_arready = 1'b0;
    forever begin
      @(negedge clk);
      m_axi_arready = 1'b0;
      if (m_axi_arvalid && !stall) begin
        repeat (ar_dly) @(negedge clk);
        if (m_axi_arvalid && !stall) begin
          m_axi_arready = 1'b1;
          araddr_log.push_back(m_axi_araddr);
          ar_cnt++;
        end
      end
    end
  end

  initial begin
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = '0;
    m_axi_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      if (r_cnt < ar_cnt && m_axi_rready && !stall_r) begin
        repeat (r_dly) @(negedge clk);
        if (rdata_q.size() != 0) m_axi_rdata = rdata_q.pop_front();
        else                     m_axi_rdata = '0;
        if (rresp_q.size() != 0) m_axi_rresp = rresp_q.pop_front();
        else                     m_axi_rresp = 2'b00;
        m_axi_rvalid = 1'b1;
        r_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // For WAIT_INTR a nonzero resp argument means a watchdog abort is expected.
  task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] rd, input logic [1:0] resp);
    int t;
    case (op)
      OP_WRITE: begin
        bresp_q.push_back(resp);
        exp_aw_q.push_back(addr);
        exp_wd_q.push_back(data);
        exp_data_q.push_back('0);
        exp_err_q.push_back(resp != 2'b00);
      end
      OP_READ, OP_READ_CMP: begin
        rdata_q.push_back(rd);
        rresp_q.push_back(resp);
        exp_ar_q.push_back(addr);
        exp_data_q.push_back(rd);
        exp_err_q.push_back(resp != 2'b00);
        if (op == OP_READ_CMP) begin
          if (rd == data) begin if (m_match < 65535) m_match++; end
          else            begin if (m_mis < 65535)   m_mis++;   end
        end
      end
      default: begin
        exp_data_q.push_back('0);
        exp_err_q.push_back(resp != 2'b00);
      end
    endcase
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("push_accept", cmd_ready, 1);
    else @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int t;
    int hold;
    logic [31:0] ed;
    logic ee;
    for (int k = 0; k < n; k++) begin
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 1000) begin
        @(negedge clk);
        t++;
      end
      chk("rsp_valid", rsp_valid, 1);
      if (!rsp_valid) return;
      ed = exp_data_q.pop_front();
      ee = exp_err_q.pop_front();
      chk("rsp_data", rsp_data, ed);
      chk("rsp_err", rsp_err, ee);
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        chk("rsp_hold", {rsp_valid, rsp_data, rsp_err}, {1'b1, ed, ee});
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic check_logs();
    while (exp_aw_q.size() != 0) begin
      chk("awaddr", (awaddr_log.size() != 0) ? awaddr_log.pop_front() : 32'hxxxx_xxxx, exp_aw_q.pop_front());
      chk("wdata", (wdata_log.size() != 0) ? wdata_log.pop_front() : 32'hxxxx_xxxx, exp_wd_q.pop_front());
      chk("wstrb", (wstrb_log.size() != 0) ? wstrb_log.pop_front() : 4'hx, 4'hF);
    end
    while (exp_ar_q.size() != 0)
      chk("araddr", (araddr_log.size() != 0) ? araddr_log.pop_front() : 32'hxxxx_xxxx, exp_ar_q.pop_front());
    chk("aw_extra", awaddr_log.size(), 0);
    chk("ar_extra", araddr_log.size(), 0);
    chk("match_count", match_count, m_match);
    chk("mismatch_count", mismatch_count, m_mis);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, '0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int t;
    int n;
    logic [1:0]  op;
    logic [31:0] d, rd;
    offs = '{REG_WEIGHT, REG_BIAS, REG_RESULT, REG_LAYER, REG_NEURON, REG_NEURON_OUT, REG_STATUS, REG_SOFT_RESET};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; intr_in = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_counts", {match_count, mismatch_count}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write with AW accepted three cycles before W.
    aw_dly = 0; w_dly = 3;
    push(OP_WRITE, REG_LAYER, 32'd1, 0, 2'b00);
    drain(1);
    check_logs();
    chk("aw_hs_wvalid_high", aw_hs_wvalid, 1);
    chk("w_hs_awvalid_low", w_hs_awvalid, 0);
    chk("b_handshakes", b_cnt, 1);
    chk("prot", {m_axi_awprot, m_axi_arprot}, '0);
    w_dly = 0;

    // Compare reads: one equal, one unequal.
    push(OP_READ_CMP, REG_RESULT, 32'd7, 32'd7, 2'b00);
    push(OP_READ_CMP, REG_RESULT, 32'd3, 32'd5, 2'b00);
    drain(2);
    check_logs();

    // Error response on a write leaves counters alone.
    push(OP_WRITE, REG_BIAS, 32'hDEAD_BEEF, 0, RESP_SLVERR);
    drain(1);
    check_logs();

    // Interrupt pulse seen before the wait command is queued.
    @(negedge clk); intr_in = 1'b1;
    @(negedge clk); intr_in = 1'b0;
    repeat (3) @(negedge clk);
    push(OP_WAIT_INTR, '0, '0, '0, 2'b00);
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk("wait_fast_latency_ok", (t <= 3), 1);
    drain(1);

    // No pulse: watchdog aborts the wait.
    push(OP_WAIT_INTR, '0, '0, '0, 2'b01);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
      if (t == 40) chk("timeout_not_early", timeout_err, 0);
    end
    chk("wait_timeout_latency_ok", (t >= 64 && t <= 66), 1);
    chk("timeout_err_set", timeout_err, 1);
    drain(1);

    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    m_match = 0; m_mis = 0;
    chk("clr_counts", {match_count, mismatch_count}, '0);
    chk("clr_timeout", timeout_err, 0);

    // Fill the FIFO behind a stalled first command.
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      op = 2'($urandom_range(0, 2));
      d  = $urandom;
      rd = $urandom_range(0, 1) ? d : $urandom;
      push(op, offs[$urandom_range(0, 7)], d, rd, 2'b00);
    end
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    stall = 1'b0;
    drain(17);
    check_logs();

    // Randomized batches with random channel delays and responses.
    for (int b = 0; b < 8; b++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        op = 2'($urandom_range(0, 2));
        d  = $urandom;
        rd = $urandom_range(0, 1) ? d : $urandom;
        push(op, offs[$urandom_range(0, 7)], d, rd, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      drain(n);
    end
    check_logs();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    // Reset while waiting for read data, with a second command queued.
    stall_r = 1'b1;
    n = ar_cnt;
    push(OP_READ, REG_STATUS, '0, 32'h55, 2'b00);
    push(OP_WRITE, REG_SOFT_RESET, 32'd1, '0, 2'b00);
    t = 0;
    while (ar_cnt == n && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("pre_reset_rready", m_axi_rready, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_counts", {match_count, mismatch_count}, '0);
    exp_data_q.delete(); exp_err_q.delete(); exp_aw_q.delete(); exp_wd_q.delete(); exp_ar_q.delete();
    bresp_q.delete(); rresp_q.delete(); rdata_q.delete();
    awaddr_log.delete(); wdata_log.delete(); wstrb_log.delete(); araddr_log.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    m_match = 0; m_mis = 0;
    stall_r = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset");

    push(OP_READ_CMP, REG_NEURON_OUT, 32'h1234, 32'h1234, 2'b00);
    drain(1);
    check_logs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
